// File: rtl/pixel_readout_buffer_if.sv
// Pixel readout buffer bus: row capture inputs and the pixel stream handshake.
// master = environment (exposure control / consumer), slave = the buffer.
interface pixel_readout_buffer_if;
  logic       ADC;
  logic       NRE_1;
  logic       NRE_2;
  logic [7:0] Data_1;
  logic [7:0] Data_2;
  logic [7:0] Pix_data;
  logic [1:0] Pix_addr;
  logic       Pix_valid;
  logic       Pix_ready;
  logic       Frame_done;
  logic       Row_err;
  logic       Ovf;
  logic [7:0] Frame_sum;

  modport master (
    output ADC, NRE_1, NRE_2, Data_1, Data_2, Pix_ready,
    input  Pix_data, Pix_addr, Pix_valid, Frame_done, Row_err, Ovf, Frame_sum
  );

  modport slave (
    input  ADC, NRE_1, NRE_2, Data_1, Data_2, Pix_ready,
    output Pix_data, Pix_addr, Pix_valid, Frame_done, Row_err, Ovf, Frame_sum
  );
endinterface

// File: rtl/pixel_readout_buffer.sv
// Pixel readout buffer: captures a 2x2 frame one row at a time on ADC rising
// edges and streams pixels through an 8-entry FIFO of {data, addr}.
// Optional macro READOUT_CHECKSUM_EN adds a per-frame mod-256 pixel checksum.
module pixel_readout_buffer (
  input logic                         Clk,
  input logic                         Reset,
  pixel_readout_buffer_if.slave       rb
);

  typedef enum logic {WAIT_R0, WAIT_R1} state_e;

  state_e      state_q, state_d;
  logic        adc_q, adc_d;
  logic [9:0]  mem_q [8];
  logic [9:0]  mem_d [8];
  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  count_q, count_d;
  logic        row_err_q, row_err_d;
  logic        ovf_q, ovf_d;
  logic        frame_done_q, frame_done_d;

  logic        capture;
  logic        is_row0;
  logic        is_row1;
  logic        push;
  logic        pop;
  logic [9:0]  head;
  logic [2:0]  wr_ptr_nxt;

  // Capture decode, frame FSM, FIFO pointers and sticky flags
  always_comb begin
    state_d      = state_q;
    adc_d        = rb.ADC;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    row_err_d    = row_err_q;
    ovf_d        = ovf_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    head         = mem_q[rd_ptr_q];
    wr_ptr_nxt   = wr_ptr_q + 3'd1;

    capture = rb.ADC & ~adc_q;
    is_row0 = ~rb.NRE_1 &  rb.NRE_2;
    is_row1 =  rb.NRE_1 & ~rb.NRE_2;
    pop     = (count_q != 4'd0) & rb.Pix_ready;

    if (capture) begin
      if (!is_row0 && !is_row1) begin
        row_err_d = 1'b1;
      end else if (is_row1 != (state_q == WAIT_R1)) begin
        row_err_d = 1'b1;
      end else if (count_q > 4'd6) begin
        // space is judged before any same-cycle pop frees a slot
        ovf_d = 1'b1;
      end else begin
        push = 1'b1;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q]   = {rb.Data_1, is_row1, 1'b0};
      mem_d[wr_ptr_nxt] = {rb.Data_2, is_row1, 1'b1};
      wr_ptr_d          = wr_ptr_q + 3'd2;
      state_d           = (state_q == WAIT_R0) ? WAIT_R1 : WAIT_R0;
    end

    if (pop) begin
      rd_ptr_d     = rd_ptr_q + 3'd1;
      frame_done_d = (head[1:0] == 2'd3);
    end

    count_d = count_q + (push ? 4'd2 : 4'd0) - (pop ? 4'd1 : 4'd0);
  end

  // Control state register with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= WAIT_R0;
      adc_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      row_err_q    <= 1'b0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      adc_q        <= adc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      row_err_q    <= row_err_d;
      ovf_q        <= ovf_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage; contents are don't-care while the entry is not occupied
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  assign rb.Pix_valid  = (count_q != 4'd0);
  assign rb.Pix_data   = rb.Pix_valid ? head[9:2] : '0;
  assign rb.Pix_addr   = rb.Pix_valid ? head[1:0] : '0;
  assign rb.Frame_done = frame_done_q;
  assign rb.Row_err    = row_err_q;
  assign rb.Ovf        = ovf_q;

`ifdef READOUT_CHECKSUM_EN
  logic [7:0] acc_q, acc_d;
  logic [7:0] sum_q, sum_d;

  // Frame checksum: accumulate on transfer, publish with the addr-3 transfer
  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    if (pop) begin
      if (head[1:0] == 2'd3) begin
        sum_d = acc_q + head[9:2];
        acc_d = '0;
      end else begin
        acc_d = acc_q + head[9:2];
      end
    end
  end

  // Checksum registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign rb.Frame_sum = sum_q;
`else
  assign rb.Frame_sum = '0;
`endif

endmodule
